// File: rtl/alu_pkg.sv
// Shared constants for the RV32I ALU: operation codes, word width and the funct7 modifier bit.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam int FUNCT7_ALT_BIT = 5;

  function automatic logic is_shift_op(input logic [2:0] f3);
    return (f3 == ALU_SLL) || (f3 == ALU_SR);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter for SLL/SRL/SRA. It is only used when ALU_BARREL_SHIFT_EN is undefined.
module alu_serial_shifter
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] in,
  input  logic [4:0]      shamt,
  input  logic            arith,
  input  logic            dir,
  output logic            busy,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shift_q, shift_d;
  logic [4:0]      count_q, count_d;
  logic            busy_q, busy_d;

  // busy drops on the same edge as the last shift, so the result is valid shamt+1 cycles after start.
  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    busy_d  = busy_q;
    if (start) begin
      shift_d = in;
      count_d = shamt;
      busy_d  = (shamt != 5'd0);
    end else if (busy_q) begin
      if (dir) shift_d = {arith & shift_q[XLEN-1], shift_q[XLEN-1:1]};
      else     shift_d = {shift_q[XLEN-2:0], 1'b0};
      count_d = count_q - 5'd1;
      busy_d  = (count_q != 5'd1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign result = shift_q;

endmodule

// File: rtl/alu.sv
// RV32I OP/OP-IMM ALU for the execute stage. Shifts are serial by default;
// defining ALU_BARREL_SHIFT_EN selects a combinational barrel shifter instead.
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            is_imm,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            ready,
  output logic [XLEN-1:0] out,
  output logic            done
);

  logic            alt;
  logic            use_sub;
  logic            op_is_shift;
  logic            ready_eff;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] shift_res;
  logic            unused_funct7;

  assign alt           = funct7[FUNCT7_ALT_BIT];
  assign use_sub       = alt & ~is_imm;
  assign op_is_shift   = is_shift_op(funct3);
  assign ready_eff     = ready & rst;
  assign sum           = in1 + (use_sub ? ~in2 : in2) + {{(XLEN-1){1'b0}}, use_sub};
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

`ifdef ALU_BARREL_SHIFT_EN
  logic unused_barrel;

  always_comb begin
    if (funct3 == ALU_SLL) shift_res = in1 << in2[4:0];
    else if (alt)          shift_res = $unsigned($signed(in1) >>> in2[4:0]);
    else                   shift_res = in1 >> in2[4:0];
  end

  assign done          = 1'b1;
  assign unused_barrel = clk ^ ready_eff;
`else
  logic busy;

  // Every accepted op restarts the shifter; a non-shift op loads a zero count so any
  // in-flight shift is abandoned and busy clears on the next edge.
  alu_serial_shifter u_shifter (
    .clk    (clk),
    .rst    (rst),
    .start  (ready_eff),
    .in     (in1),
    .shamt  (op_is_shift ? in2[4:0] : 5'd0),
    .arith  (alt),
    .dir    (funct3 == ALU_SR),
    .busy   (busy),
    .result (shift_res)
  );

  assign done = ready_eff ? ~op_is_shift : ~busy;
`endif

  always_comb begin
    out = '0;
    unique case (funct3)
      ALU_ADD:  out = sum;
      ALU_SLL:  out = shift_res;
      ALU_SLT:  out = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
      ALU_SLTU: out = {{(XLEN-1){1'b0}}, in1 < in2};
      ALU_XOR:  out = in1 ^ in2;
      ALU_SR:   out = shift_res;
      ALU_OR:   out = in1 | in2;
      ALU_AND:  out = in1 & in2;
      default:  out = '0;
    endcase
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for the ALU: the driver queues expected result and latency per op,
// a negedge monitor pops and compares whenever done is presented after a ready.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in1, in2;
  logic        is_imm;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        ready;
  logic [31:0] out;
  logic        done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] lat;
  } exp_t;

  exp_t exp_q[$];
  logic active = 1'b0;
  int   cyc = 0;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .in1    (in1),
    .in2    (in2),
    .is_imm (is_imm),
    .funct3 (funct3),
    .funct7 (funct7),
    .ready  (ready),
    .out    (out),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic imm,
                                        input logic [6:0] f7, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] ones;
    int sh;
    ones = 32'hFFFF_FFFF;
    sh = int'(b % 32);
    case (f3)
      3'd0: return (!imm && f7[5]) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return f7[5] ? ((a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0)) : (a >> sh);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] latency(input logic [2:0] f3, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 32'd0;
`else
    if (f3 == 3'd1 || f3 == 3'd5) return (b % 32) + 1;
    return 32'd0;
`endif
  endfunction

  task automatic issue(input logic [2:0] f3, input logic imm, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(posedge clk); #1;
    funct3 = f3; is_imm = imm; funct7 = f7; in1 = a; in2 = b;
    ready = 1'b1;
    e.res = model(f3, imm, f7, a, b);
    e.lat = latency(f3, b);
    exp_q.push_back(e);
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    #1;
  endtask

  task automatic run(input logic [2:0] f3, input logic imm, input logic [6:0] f7,
                     input logic [31:0] a, input logic [31:0] b);
    issue(f3, imm, f7, a, b);
    wait_idle();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      active = 1'b0;
    end else begin
      if (ready) begin
        if (active && exp_q.size() != 0) void'(exp_q.pop_front());
        active = 1'b1;
        cyc = 0;
      end else if (active) begin
        cyc++;
      end
      if (active) begin
        if (done) begin
          active = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("out", out, e.res);
            check("latency", cyc, e.lat);
          end
        end else if (cyc > 64) begin
          active = 1'b0;
          check("done_timeout", cyc, 32'd0);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ready = 1'b0; in1 = '0; in2 = '0;
    is_imm = 1'b0; funct3 = 3'd0; funct7 = 7'd0;
    #3;
    check("reset_done", done, 1'b1);
    check("reset_out", out, 32'd0);
    @(posedge clk); #1;
    ready = 1'b1;
    #1;
    check("ready_in_reset_done", done, 1'b1);
    ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    run(3'b000, 1'b0, 7'h20, 32'd5, 32'd7);
    run(3'b000, 1'b1, 7'h20, 32'd5, 32'd7);
    run(3'b010, 1'b0, 7'h00, 32'hFFFF_FFFF, 32'd1);
    run(3'b011, 1'b0, 7'h00, 32'hFFFF_FFFF, 32'd1);
    run(3'b100, 1'b0, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run(3'b110, 1'b0, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run(3'b111, 1'b0, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0);

    run(3'b101, 1'b0, 7'h20, 32'h8000_0000, 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sra_hold_out", out, 32'hF800_0000);
      check("sra_hold_done", done, 1'b1);
    end

    run(3'b001, 1'b0, 7'h00, 32'd1, 32'h21);
    run(3'b001, 1'b1, 7'h00, 32'h1234_5678, 32'd0);
    run(3'b101, 1'b1, 7'h00, 32'h8000_0000, 32'd31);
    run(3'b101, 1'b1, 7'h7F, 32'h7FFF_FFFF, 32'd31);

    // new ready while a shift is in flight abandons it
    issue(3'b101, 1'b0, 7'h00, 32'hFFFF_0000, 32'd20);
    repeat (3) @(posedge clk);
    issue(3'b000, 1'b0, 7'h00, 32'd3, 32'd4);
    wait_idle();
    issue(3'b001, 1'b0, 7'h00, 32'h0000_00FF, 32'd10);
    repeat (2) @(posedge clk);
    issue(3'b101, 1'b0, 7'h20, 32'h8000_00F0, 32'd3);
    wait_idle();

    // asynchronous reset in the middle of a long shift
    issue(3'b001, 1'b0, 7'h00, 32'd1, 32'd31);
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_done", done, 1'b1);
`ifdef ALU_BARREL_SHIFT_EN
    check("rst_mid_out", out, 32'h8000_0000);
`else
    check("rst_mid_out", out, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    run(3'b000, 1'b0, 7'h00, 32'd100, 32'd23);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] b;
      b = $urandom;
      if ($urandom_range(0, 1) == 1) b = b & 32'h0000_003F;
      run(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 7'($urandom), $urandom, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
